// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the DMA/loader port using a
// registered-grant FSM with round-robin tie-break and a burst cap against starvation.
module dmem_arbiter #(
   parameter int AW        = 16,
   parameter int DW        = 16,
   parameter int MAX_BURST = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [DW-1:0] cpu_wdata_i,
   output logic          cpu_gnt_o,
   output logic          cpu_rvalid_o,
   output logic [DW-1:0] cpu_rdata_o,
   input  logic          dma_req_i,
   input  logic          dma_we_i,
   input  logic [AW-1:0] dma_addr_i,
   input  logic [DW-1:0] dma_wdata_i,
   output logic          dma_gnt_o,
   output logic          dma_rvalid_o,
   output logic [DW-1:0] dma_rdata_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [1:0]  IDLE      = 2'd0;
   localparam logic [1:0]  OWN_CPU   = 2'd1;
   localparam logic [1:0]  OWN_DMA   = 2'd2;
   localparam logic        OWNER_CPU = 1'b0;
   localparam logic        OWNER_DMA = 1'b1;
   localparam logic [CW:0]   MAX_BEATS = (CW + 1)'(MAX_BURST);
   localparam logic [CW-1:0] SAT_CNT   = CW'(MAX_BURST);

   logic [1:0]    state_q, state_d;
   logic          last_owner_q, last_owner_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_tag_q, rd_tag_d;
   logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0] dma_rdata_q, dma_rdata_d;

   logic          own_dma;
   logic          own_req;
   logic          own_we;
   logic          accept;
   logic [CW:0]   beats_seen;
   logic          burst_done;

   assign cpu_gnt_o = (state_q == OWN_CPU);
   assign dma_gnt_o = (state_q == OWN_DMA);
   assign own_dma   = dma_gnt_o;

   // The CPU side drives the memory bus while idle; mem_we stays low there regardless.
   assign own_req     = own_dma ? dma_req_i   : cpu_req_i;
   assign own_we      = own_dma ? dma_we_i    : cpu_we_i;
   assign mem_addr_o  = own_dma ? dma_addr_i  : cpu_addr_i;
   assign mem_wdata_o = own_dma ? dma_wdata_i : cpu_wdata_i;
   assign accept      = (cpu_gnt_o | dma_gnt_o) & own_req;
   assign mem_we_o    = accept & own_we;

   assign beats_seen = {1'b0, beat_cnt_q} + {{CW{1'b0}}, accept};
   assign burst_done = (beats_seen >= MAX_BEATS);

   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      beat_cnt_d   = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (cpu_req_i && (!dma_req_i || last_owner_q == OWNER_DMA)) begin
               state_d = OWN_CPU;
            end else if (dma_req_i) begin
               state_d = OWN_DMA;
            end
         end
         OWN_CPU: begin
            if (!cpu_req_i) begin
               state_d = dma_req_i ? OWN_DMA : IDLE;
            end else if (dma_req_i && burst_done) begin
               state_d = OWN_DMA;
            end else begin
               beat_cnt_d = burst_done ? SAT_CNT : beats_seen[CW-1:0];
            end
         end
         OWN_DMA: begin
            if (!dma_req_i) begin
               state_d = cpu_req_i ? OWN_CPU : IDLE;
            end else if (cpu_req_i && burst_done) begin
               state_d = OWN_CPU;
            end else begin
               beat_cnt_d = burst_done ? SAT_CNT : beats_seen[CW-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
      // Every fresh ownership starts a new burst and records who last won.
      if (state_d == OWN_CPU && state_q != OWN_CPU) begin
         last_owner_d = OWNER_CPU;
         beat_cnt_d   = '0;
      end else if (state_d == OWN_DMA && state_q != OWN_DMA) begin
         last_owner_d = OWNER_DMA;
         beat_cnt_d   = '0;
      end
   end

   // The read tag is captured at accept so a response follows its issuer across a handoff.
   assign rd_pend_d = accept & ~own_we;
   assign rd_tag_d  = rd_pend_d ? own_dma : rd_tag_q;

   assign cpu_rvalid_o = rd_pend_q & (rd_tag_q == OWNER_CPU);
   assign dma_rvalid_o = rd_pend_q & (rd_tag_q == OWNER_DMA);
   assign cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : cpu_rdata_q;
   assign dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : dma_rdata_q;
   assign cpu_rdata_d  = cpu_rdata_o;
   assign dma_rdata_d  = dma_rdata_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         last_owner_q <= OWNER_DMA;
         beat_cnt_q   <= '0;
         rd_pend_q    <= 1'b0;
         rd_tag_q     <= OWNER_CPU;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         beat_cnt_q   <= beat_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_tag_q     <= rd_tag_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

endmodule
